// File: rtl/eth_mdio_pkg.sv
// Shared definitions for the clause-22 MDIO responder: FSM encoding, opcodes
// and frame field widths.
package eth_mdio_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA,
        S_SKIP
    } mdio_state_t;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] TA_WRITE = 2'b10;

    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int DATA_W  = 16;

    // A frame addressed to another PHY still owns the bus for TA plus DATA.
    localparam int SKIP_BITS = 2 + DATA_W;

    function automatic logic op_valid(input logic [1:0] op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/eth_mdio_sync.sv
// Multi-flop synchronizer with registered previous value, giving a level plus
// single-Clk rise/fall pulses for an asynchronous pad input.
module eth_mdio_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/eth_mdio_responder.sv
// PHY-side clause-22 MDIO responder: oversamples MDC/MDIO, decodes frames,
// strobes an external register bank and drives read data back on MDIO.
module eth_mdio_responder
    import eth_mdio_pkg::*;
#(
    parameter int PREAMBLE_MIN = 32,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mdc,
    input  logic        i_mdio_in,
    output logic        o_mdio_out,
    output logic        o_mdio_oe,
    input  logic [4:0]  i_phy_addr,
    output logic [4:0]  o_reg_addr,
    output logic [15:0] o_reg_wr_data,
    output logic        o_reg_wr,
    output logic        o_reg_rd,
    input  logic [15:0] i_reg_rd_data,
    output logic        o_busy,
    output logic        o_frame_err
);

    localparam int              PRE_W   = $clog2(PREAMBLE_MIN + 2);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PREAMBLE_MIN);

    logic w_mdc_sync, w_mdc_rise, w_mdc_fall;
    logic w_bit, w_mdio_rise, w_mdio_fall;
    logic w_unused;

    eth_mdio_sync #(.STAGES(SYNC_STAGES)) u_sync_mdc (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_mdc),
        .o_sync (w_mdc_sync),
        .o_rise (w_mdc_rise),
        .o_fall (w_mdc_fall)
    );

    eth_mdio_sync #(.STAGES(SYNC_STAGES)) u_sync_mdio (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_mdio_in),
        .o_sync (w_bit),
        .o_rise (w_mdio_rise),
        .o_fall (w_mdio_fall)
    );

    assign w_unused = &{1'b0, w_mdc_sync, w_mdio_rise, w_mdio_fall};

    mdio_state_t        r_state, w_state_nxt;
    logic [4:0]         r_cnt, w_cnt_nxt;
    logic [PRE_W-1:0]   r_pre_cnt;
    logic               r_op0;
    logic               r_is_read;
    logic [PHYAD_W-1:0] r_phy;
    logic [REGAD_W-2:0] r_reg;
    logic               r_ta0;
    logic [DATA_W-1:0]  r_data;

    logic w_err, w_wr, w_rd, w_addr_upd, w_match;

    assign w_match = (r_phy == i_phy_addr);
    assign o_busy  = (r_state != S_IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Every decision is taken on a sampled MDC rise; r_cnt is the bit index
    // within the current field.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err       = 1'b0;
        w_wr        = 1'b0;
        w_rd        = 1'b0;
        w_addr_upd  = 1'b0;
        if (w_mdc_rise) begin
            w_cnt_nxt = r_cnt + 5'd1;
            unique case (r_state)
                S_IDLE: begin
                    w_cnt_nxt = '0;
                    if (!w_bit && (r_pre_cnt >= PRE_MAX))
                        w_state_nxt = S_ST;
                end
                S_ST: begin
                    w_cnt_nxt = '0;
                    if (w_bit) begin
                        w_state_nxt = S_OP;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_OP: if (r_cnt == 5'd1) begin
                    w_cnt_nxt = '0;
                    if (op_valid({r_op0, w_bit})) begin
                        w_state_nxt = S_PHYAD;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_PHYAD: if (r_cnt == 5'(PHYAD_W - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_REGAD;
                end
                S_REGAD: if (r_cnt == 5'(REGAD_W - 1)) begin
                    w_cnt_nxt = '0;
                    if (w_match) begin
                        w_state_nxt = S_TA;
                        w_addr_upd  = 1'b1;
                        w_rd        = r_is_read;
                    end else begin
                        w_state_nxt = S_SKIP;
                    end
                end
                S_TA: if (r_cnt == 5'd1) begin
                    w_cnt_nxt = '0;
                    if (!r_is_read && ({r_ta0, w_bit} != TA_WRITE)) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
                S_DATA: if (r_cnt == 5'(DATA_W - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_wr        = !r_is_read;
                end
                S_SKIP: if (r_cnt == 5'(SKIP_BITS - 1)) begin
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pre_cnt <= '0;
        end else if (r_state != S_IDLE) begin
            r_pre_cnt <= '0;
        end else if (w_mdc_rise) begin
            if (!w_bit)
                r_pre_cnt <= '0;
            else if (r_pre_cnt < PRE_MAX)
                r_pre_cnt <= r_pre_cnt + PRE_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op0         <= 1'b0;
            r_is_read     <= 1'b0;
            r_phy         <= '0;
            r_reg         <= '0;
            r_ta0         <= 1'b0;
            r_data        <= '0;
            o_reg_addr    <= '0;
            o_reg_wr_data <= '0;
            o_reg_wr      <= 1'b0;
            o_reg_rd      <= 1'b0;
            o_frame_err   <= 1'b0;
            o_mdio_out    <= 1'b0;
            o_mdio_oe     <= 1'b0;
        end else begin
            o_reg_wr    <= w_wr;
            o_reg_rd    <= w_rd;
            o_frame_err <= w_err;

            if (w_mdc_rise) begin
                case (r_state)
                    S_OP: begin
                        if (r_cnt == 5'd0)
                            r_op0 <= w_bit;
                        else
                            r_is_read <= ({r_op0, w_bit} == OP_READ);
                    end
                    S_PHYAD: r_phy <= {r_phy[PHYAD_W-2:0], w_bit};
                    S_REGAD: begin
                        r_reg <= {r_reg[REGAD_W-3:0], w_bit};
                        if (w_addr_upd)
                            o_reg_addr <= {r_reg, w_bit};
                    end
                    S_TA: if (r_cnt == 5'd0) r_ta0 <= w_bit;
                    S_DATA: if (!r_is_read) begin
                        r_data <= {r_data[DATA_W-2:0], w_bit};
                        if (w_wr)
                            o_reg_wr_data <= {r_data[DATA_W-2:0], w_bit};
                    end
                    default: ;
                endcase
            end

            // Read data is captured one Clk after the request pulse.
            if (o_reg_rd)
                r_data <= i_reg_rd_data;

            // Pad changes only on MDC fall: TA second half drives 0, then
            // data MSB first; anything else releases the pad.
            if (w_mdc_fall) begin
                if ((r_state == S_TA) && r_is_read && (r_cnt == 5'd1)) begin
                    o_mdio_oe  <= 1'b1;
                    o_mdio_out <= 1'b0;
                end else if ((r_state == S_DATA) && r_is_read) begin
                    o_mdio_out <= r_data[DATA_W-1];
                    r_data     <= {r_data[DATA_W-2:0], 1'b0};
                end else begin
                    o_mdio_oe  <= 1'b0;
                    o_mdio_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_mdio_responder.sv
// Directed bench for eth_mdio_responder: a table of whole frames plus
// hand-written read, reset-during-read and preamble-suppression sequences.
module tb_eth_mdio_responder;
    import eth_mdio_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mdc = 1'b0;
    logic        mdio = 1'b1;
    logic        mdio2 = 1'b1;
    logic        sel = 1'b0;
    logic [4:0]  pa = 5'd1;
    logic [4:0]  pa2 = 5'd2;
    logic [15:0] rd_data = 16'hDEAD;

    logic        mdio_out, mdio_oe, reg_wr, reg_rd, busy, frame_err;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wr_data;
    logic        mdio_out2, mdio_oe2, reg_wr2, reg_rd2, busy2, frame_err2;
    logic [4:0]  reg_addr2;
    logic [15:0] reg_wr_data2;

    always #5 clk = ~clk;

    eth_mdio_responder dut (
        .i_clk(clk), .i_rst(rst), .i_mdc(mdc), .i_mdio_in(mdio),
        .o_mdio_out(mdio_out), .o_mdio_oe(mdio_oe), .i_phy_addr(pa),
        .o_reg_addr(reg_addr), .o_reg_wr_data(reg_wr_data), .o_reg_wr(reg_wr),
        .o_reg_rd(reg_rd), .i_reg_rd_data(rd_data), .o_busy(busy),
        .o_frame_err(frame_err)
    );

    eth_mdio_responder #(.PREAMBLE_MIN(0)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_mdc(mdc), .i_mdio_in(mdio2),
        .o_mdio_out(mdio_out2), .o_mdio_oe(mdio_oe2), .i_phy_addr(pa2),
        .o_reg_addr(reg_addr2), .o_reg_wr_data(reg_wr_data2), .o_reg_wr(reg_wr2),
        .o_reg_rd(reg_rd2), .i_reg_rd_data(16'h0000), .o_busy(busy2),
        .o_frame_err(frame_err2)
    );

    int wr_n = 0, rd_n = 0, err_n = 0, oe_n = 0, busy_n = 0;
    int wr2_n = 0, err2_n = 0, clash_n = 0;

    // Pulse counters plus a register bank whose data is valid only in the Clk
    // following the read request.
    always @(negedge clk) begin
        if (reg_wr)    wr_n++;
        if (reg_rd)    rd_n++;
        if (frame_err) err_n++;
        if (mdio_oe)   oe_n++;
        if (busy)      busy_n++;
        if (reg_wr2)   wr2_n++;
        if (frame_err2) err2_n++;
        if ((reg_wr && frame_err) || (reg_wr && reg_rd) || (reg_wr2 && frame_err2)) clash_n++;
        rd_data = reg_rd ? 16'h1234 : 16'hDEAD;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One MDC period of 12 Clk; pad outputs are sampled just before the rise.
    task automatic cyc(input logic b, output logic s_oe, output logic s_out);
        clks(2);
        if (sel) mdio2 = b; else mdio = b;
        clks(4);
        s_oe  = mdio_oe;
        s_out = mdio_out;
        mdc = 1'b1;
        clks(6);
        mdc = 1'b0;
    endtask

    task automatic bitc(input logic b);
        logic so, sd;
        cyc(b, so, sd);
    endtask

    task automatic ones(input int n);
        repeat (n) bitc(1'b1);
    endtask

    task automatic sendw(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) bitc(w[i]);
    endtask

    function automatic logic [31:0] mk(input logic [1:0] st, input logic [1:0] op,
                                       input logic [4:0] phy, input logic [4:0] rg,
                                       input logic [1:0] ta, input logic [15:0] d);
        return {st, op, phy, rg, ta, d};
    endfunction

    typedef struct {
        logic [4:0]  pa;
        int          pre;
        logic [31:0] body;
        int          e_wr;
        int          e_rd;
        int          e_err;
        logic        e_busy;
        logic [4:0]  e_addr;
        logic [15:0] e_wdata;
    } vec_t;

    vec_t v[10];

    initial begin
        int b_wr, b_rd, b_err, b_oe, b_busy, b_wr2;
        logic so, sd, oe_all;
        logic [15:0] word;

        v[0] = '{5'd1, 32, mk(2'b01, OP_WRITE, 5'd1, 5'd5,  2'b10, 16'hA5C3), 1, 0, 0, 1'b1, 5'd5,  16'hA5C3};
        v[1] = '{5'd1, 31, mk(2'b01, OP_WRITE, 5'd1, 5'd7,  2'b10, 16'h1111), 0, 0, 0, 1'b0, 5'd5,  16'hA5C3};
        v[2] = '{5'd1, 32, mk(2'b01, 2'b11,    5'd1, 5'd5,  2'b10, 16'h0000), 0, 0, 1, 1'b1, 5'd5,  16'hA5C3};
        v[3] = '{5'd1, 32, mk(2'b01, OP_WRITE, 5'd1, 5'd9,  2'b11, 16'hBEEF), 0, 0, 1, 1'b1, 5'd9,  16'hA5C3};
        v[4] = '{5'd3, 32, mk(2'b01, OP_WRITE, 5'd1, 5'd4,  2'b10, 16'h5555), 0, 0, 0, 1'b1, 5'd9,  16'hA5C3};
        v[5] = '{5'd3, 32, mk(2'b01, OP_READ,  5'd1, 5'd6,  2'b11, 16'hFFFF), 0, 0, 0, 1'b1, 5'd9,  16'hA5C3};
        v[6] = '{5'd3, 32, mk(2'b01, OP_WRITE, 5'd3, 5'd31, 2'b10, 16'h8001), 1, 0, 0, 1'b1, 5'd31, 16'h8001};
        v[7] = '{5'd0, 32, mk(2'b01, OP_WRITE, 5'd0, 5'd3,  2'b10, 16'h0F0F), 1, 0, 0, 1'b1, 5'd3,  16'h0F0F};
        v[8] = '{5'd3, 32, mk(2'b01, OP_WRITE, 5'd0, 5'd8,  2'b10, 16'hFFFF), 0, 0, 0, 1'b1, 5'd3,  16'h0F0F};
        v[9] = '{5'd1, 32, mk(2'b00, OP_WRITE, 5'd1, 5'd5,  2'b10, 16'h0000), 0, 0, 1, 1'b1, 5'd3,  16'h0F0F};

        clks(4);
        rst = 1'b0;
        clks(4);
        chk("rst_mdio_out", {31'd0, mdio_out},  32'd0);
        chk("rst_mdio_oe",  {31'd0, mdio_oe},   32'd0);
        chk("rst_reg_addr", {27'd0, reg_addr},  32'd0);
        chk("rst_wr_data",  {16'd0, reg_wr_data}, 32'd0);
        chk("rst_reg_wr",   {31'd0, reg_wr},    32'd0);
        chk("rst_reg_rd",   {31'd0, reg_rd},    32'd0);
        chk("rst_busy",     {31'd0, busy},      32'd0);
        chk("rst_frame_err",{31'd0, frame_err}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            pa = v[i].pa;
            b_wr = wr_n; b_rd = rd_n; b_err = err_n; b_oe = oe_n; b_busy = busy_n;
            bitc(1'b0);
            ones(v[i].pre);
            sendw(v[i].body, 32);
            ones(2);
            chk($sformatf("v%0d_wr", i),    wr_n - b_wr,   v[i].e_wr);
            chk($sformatf("v%0d_rd", i),    rd_n - b_rd,   v[i].e_rd);
            chk($sformatf("v%0d_err", i),   err_n - b_err, v[i].e_err);
            chk($sformatf("v%0d_oe", i),    oe_n - b_oe,   0);
            chk($sformatf("v%0d_busy", i),  {31'd0, busy_n != b_busy}, {31'd0, v[i].e_busy});
            chk($sformatf("v%0d_addr", i),  {27'd0, reg_addr},    {27'd0, v[i].e_addr});
            chk($sformatf("v%0d_wdata", i), {16'd0, reg_wr_data}, {16'd0, v[i].e_wdata});
        end

        // Read of register 2, checked bit by bit at the host's sampling points.
        pa = 5'd1;
        b_wr = wr_n; b_rd = rd_n;
        bitc(1'b0);
        ones(32);
        sendw({18'd0, 2'b01, OP_READ, 5'd1, 5'd2}, 14);
        cyc(1'b1, so, sd);
        chk("rd_ta1_oe", {31'd0, so}, 32'd0);
        cyc(1'b1, so, sd);
        chk("rd_ta2_oe",  {31'd0, so}, 32'd1);
        chk("rd_ta2_out", {31'd0, sd}, 32'd0);
        oe_all = 1'b1;
        word = '0;
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, so, sd);
            oe_all &= so;
            word[15-k] = sd;
        end
        chk("rd_data_oe",  {31'd0, oe_all}, 32'd1);
        chk("rd_data_word", {16'd0, word}, 32'h1234);
        cyc(1'b1, so, sd);
        chk("rd_post_oe", {31'd0, so}, 32'd0);
        chk("rd_pulses",  rd_n - b_rd, 1);
        chk("rd_no_wr",   wr_n - b_wr, 0);
        chk("rd_addr",    {27'd0, reg_addr}, 32'd2);
        ones(2);

        // Reset while read data bit 7 is on the pad.
        bitc(1'b0);
        ones(32);
        sendw({18'd0, 2'b01, OP_READ, 5'd1, 5'd2}, 14);
        ones(2 + 7);
        clks(6);
        chk("mid_rd_oe", {31'd0, mdio_oe}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_oe",   {31'd0, mdio_oe}, 32'd0);
        chk("rst_async_busy", {31'd0, busy},    32'd0);
        clks(3);
        rst = 1'b0;
        clks(2);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_addr", {27'd0, reg_addr}, 32'd0);
        b_wr = wr_n;
        bitc(1'b0);
        ones(32);
        sendw(mk(2'b01, OP_WRITE, 5'd1, 5'd10, 2'b10, 16'h3C3C), 32);
        ones(2);
        chk("post_rst_wr",    wr_n - b_wr, 1);
        chk("post_rst_waddr", {27'd0, reg_addr}, 32'd10);
        chk("post_rst_wdata", {16'd0, reg_wr_data}, 32'h3C3C);

        // Preamble suppression: two writes with no idle bits between them.
        sel = 1'b1;
        b_wr2 = wr2_n;
        ones(2);
        sendw(mk(2'b01, OP_WRITE, 5'd2, 5'd1, 2'b10, 16'h1111), 32);
        sendw(mk(2'b01, OP_WRITE, 5'd2, 5'd4, 2'b10, 16'h2222), 32);
        ones(2);
        chk("sup_wr",    wr2_n - b_wr2, 2);
        chk("sup_addr",  {27'd0, reg_addr2}, 32'd4);
        chk("sup_wdata", {16'd0, reg_wr_data2}, 32'h2222);
        chk("sup_err",   err2_n, 0);
        chk("strobe_clash", clash_n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
